// File: rtl/matriz_pkg.sv
// ---------------------------------------------------------------------------
// matriz_pkg
// Shared constants and state encoding for the matrix coprocessor host side.
//   LARGURA  : element width in bits
//   N_ELEM   : elements per 5x5 matrix
//   BASE_RES : RAM base address of the result matrix
//   AW       : RAM address width
//   BUS_W    : width of one packed matrix bus
// ---------------------------------------------------------------------------
package matriz_pkg;

  localparam int LARGURA  = 9;
  localparam int N_ELEM   = 25;
  localparam int BASE_RES = 50;
  localparam int AW       = 8;
  localparam int BUS_W    = LARGURA * N_ELEM;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ESCREVE = 3'd1,
    AGUARDA = 3'd2,
    LE      = 3'd3,
    FIM     = 3'd4
  } estado_t;

endpackage

// File: rtl/carrega_matriz.sv
// ---------------------------------------------------------------------------
// carrega_matriz
// Host-side loader/unloader for the coprocessor RAM. Serialises two packed
// operand matrices into RAM addresses 0..2*N_ELEM-1, waits for the
// coprocessor, then reads N_ELEM results back from BASE_RES onward and
// presents them as one packed bus.
//
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   start              : begin an operation (sampled only when idle)
//   matriz_a/matriz_b  : packed operands, element k at [LARGURA*k +: LARGURA]
//   resultado_pronto   : coprocessor done level (sampled only in AGUARDA)
//   dado_entrada       : RAM read data (synchronous read, 1-cycle latency)
//   endereco           : RAM address
//   dado_saida         : RAM write data
//   grava              : RAM write enable
//   ocupado            : high whenever not idle
//   carregado          : high while waiting for the coprocessor
//   concluido          : one-cycle pulse while the new result is presented
//   matriz_resultante  : packed result, same packing as the operands
//
// Every output is a flop. The output flops are loaded from the *next* state
// and counter, so the values seen during a cycle always belong to the state
// occupied during that same cycle.
// ---------------------------------------------------------------------------
module carrega_matriz
  import matriz_pkg::*;
#(
  parameter int LARGURA  = matriz_pkg::LARGURA,
  parameter int N_ELEM   = matriz_pkg::N_ELEM,
  parameter int BASE_RES = matriz_pkg::BASE_RES,
  parameter int AW       = matriz_pkg::AW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LARGURA*N_ELEM-1:0]   matriz_a,
  input  logic [LARGURA*N_ELEM-1:0]   matriz_b,
  input  logic                        resultado_pronto,
  input  logic [LARGURA-1:0]          dado_entrada,
  output logic [AW-1:0]               endereco,
  output logic [LARGURA-1:0]          dado_saida,
  output logic                        grava,
  output logic                        ocupado,
  output logic                        carregado,
  output logic                        concluido,
  output logic [LARGURA*N_ELEM-1:0]   matriz_resultante
);

  localparam int BUS = LARGURA * N_ELEM;
  localparam int CW  = $clog2(2 * N_ELEM);  // counter covers 0..2*N_ELEM-1
  localparam int OW  = $clog2(2 * BUS);     // bit offset into both operands
  localparam int SW  = $clog2(BUS);         // bit offset into one matrix

  localparam logic [CW-1:0] ULT_ESC = CW'(2 * N_ELEM - 1);  // last write index
  localparam logic [CW-1:0] ULT_LE  = CW'(N_ELEM);          // drain cycle index
  localparam logic [CW-1:0] ULT_END = CW'(N_ELEM - 1);      // last read index

  estado_t             estado;
  estado_t             estado_nx;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nx;
  logic [2*BUS-1:0]    operandos;
  logic [2*BUS-1:0]    ops_fonte;
  logic [BUS-1:0]      sombra;
  logic [BUS-1:0]      sombra_nx;
  logic [OW-1:0]       off_op;
  logic [SW-1:0]       off_sb;
  logic [CW-1:0]       end_le;

  logic [AW-1:0]       endereco_nx;
  logic [LARGURA-1:0]  dado_saida_nx;
  logic                grava_nx;
  logic                ocupado_nx;
  logic                carregado_nx;
  logic                concluido_nx;
  logic [BUS-1:0]      resultado_nx;

  // State register and element counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
      cnt    <= {CW{1'b0}};
    end else begin
      estado <= estado_nx;
      cnt    <= cnt_nx;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    estado_nx = estado;
    cnt_nx    = cnt;
    case (estado)
      OCIOSO: begin
        if (start) begin
          estado_nx = ESCREVE;
          cnt_nx    = {CW{1'b0}};
        end else begin
          estado_nx = OCIOSO;
        end
      end
      ESCREVE: begin
        if (cnt == ULT_ESC) begin
          estado_nx = AGUARDA;
          cnt_nx    = {CW{1'b0}};
        end else begin
          cnt_nx    = cnt + CW'(1);
        end
      end
      AGUARDA: begin
        if (resultado_pronto) begin
          estado_nx = LE;
          cnt_nx    = {CW{1'b0}};
        end else begin
          estado_nx = AGUARDA;
        end
      end
      LE: begin
        if (cnt == ULT_LE) begin
          estado_nx = FIM;
          cnt_nx    = {CW{1'b0}};
        end else begin
          cnt_nx    = cnt + CW'(1);
        end
      end
      FIM: begin
        estado_nx = OCIOSO;
        cnt_nx    = {CW{1'b0}};
      end
      default: begin
        estado_nx = OCIOSO;
        cnt_nx    = {CW{1'b0}};
      end
    endcase
  end

  // Operand latch, taken on the accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operandos <= {(2*BUS){1'b0}};
    end else if ((estado == OCIOSO) && start) begin
      operandos <= {matriz_b, matriz_a};
    end
  end

  // Shadow capture: read data for address j arrives one cycle after it is
  // presented, so LE cycle c (c >= 1) stores element c-1.
  always_comb begin
    sombra_nx = sombra;
    off_sb    = SW'(cnt - CW'(1)) * SW'(LARGURA);
    if ((estado == LE) && (cnt != {CW{1'b0}})) begin
      sombra_nx[off_sb +: LARGURA] = dado_entrada;
    end else begin
      sombra_nx = sombra;
    end
  end

  // Next output values, derived from the upcoming state and counter.
  always_comb begin
    // On the start edge the latch is not yet loaded, so element 0 comes
    // straight from the input buses.
    ops_fonte     = (estado == OCIOSO) ? {matriz_b, matriz_a} : operandos;
    off_op        = OW'(cnt_nx) * OW'(LARGURA);
    end_le        = (cnt_nx > ULT_END) ? ULT_END : cnt_nx;
    endereco_nx   = {AW{1'b0}};
    dado_saida_nx = {LARGURA{1'b0}};
    grava_nx      = 1'b0;
    ocupado_nx    = (estado_nx != OCIOSO);
    carregado_nx  = (estado_nx == AGUARDA);
    concluido_nx  = (estado_nx == FIM);
    resultado_nx  = matriz_resultante;
    case (estado_nx)
      ESCREVE: begin
        grava_nx      = 1'b1;
        endereco_nx   = AW'(cnt_nx);
        dado_saida_nx = ops_fonte[off_op +: LARGURA];
      end
      LE: begin
        // Drain cycle keeps the last result address on the bus.
        endereco_nx   = AW'(BASE_RES) + AW'(end_le);
      end
      FIM: begin
        // Includes the final element captured on this same edge.
        resultado_nx  = sombra_nx;
      end
      OCIOSO, AGUARDA: begin
        endereco_nx   = {AW{1'b0}};
      end
      default: begin
        endereco_nx   = {AW{1'b0}};
      end
    endcase
  end

  // Output and shadow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      endereco          <= {AW{1'b0}};
      dado_saida        <= {LARGURA{1'b0}};
      grava             <= 1'b0;
      ocupado           <= 1'b0;
      carregado         <= 1'b0;
      concluido         <= 1'b0;
      matriz_resultante <= {BUS{1'b0}};
      sombra            <= {BUS{1'b0}};
    end else begin
      endereco          <= endereco_nx;
      dado_saida        <= dado_saida_nx;
      grava             <= grava_nx;
      ocupado           <= ocupado_nx;
      carregado         <= carregado_nx;
      concluido         <= concluido_nx;
      matriz_resultante <= resultado_nx;
      sombra            <= sombra_nx;
    end
  end

endmodule

// File: tb/tb_carrega_matriz.sv
// ---------------------------------------------------------------------------
// tb_carrega_matriz
// Directed self-checking bench for carrega_matriz with a behavioural
// synchronous-read RAM (256 x 9) and an extra bench write port used to
// preload the result region.
// Comments count "edge n" from the edge that samples start (edge 0).
// ---------------------------------------------------------------------------
module tb_carrega_matriz;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [224:0] matriz_a;
  logic [224:0] matriz_b;
  logic         resultado_pronto;
  logic [8:0]   dado_entrada;
  logic [7:0]   endereco;
  logic [8:0]   dado_saida;
  logic         grava;
  logic         ocupado;
  logic         carregado;
  logic         concluido;
  logic [224:0] matriz_resultante;

  logic [8:0]   mem [0:255];
  logic         tb_we;
  logic [7:0]   tb_addr;
  logic [8:0]   tb_data;
  int           grava_cnt = 0;
  int           g0;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [224:0] exp_res;
  logic [224:0] old_res;

  carrega_matriz dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .matriz_a          (matriz_a),
    .matriz_b          (matriz_b),
    .resultado_pronto  (resultado_pronto),
    .dado_entrada      (dado_entrada),
    .endereco          (endereco),
    .dado_saida        (dado_saida),
    .grava             (grava),
    .ocupado           (ocupado),
    .carregado         (carregado),
    .concluido         (concluido),
    .matriz_resultante (matriz_resultante)
  );

  always #5 clk = ~clk;

  // RAM model: write port from the DUT, bench preload port, 1-cycle read.
  always @(posedge clk) begin
    if (grava) mem[endereco] <= dado_saida;
    if (tb_we) mem[tb_addr] <= tb_data;
    dado_entrada <= mem[endereco];
  end

  // Count RAM write edges.
  always @(posedge clk) begin
    if (grava) grava_cnt <= grava_cnt + 1;
  end

  task automatic check(input string tag, input logic [224:0] obs, input logic [224:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check(tag, 225'({endereco, dado_saida, grava, ocupado, carregado, concluido}), 225'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; resultado_pronto = 1'b0; tb_we = 1'b0;
    tb_addr = 8'd0; tb_data = 9'd0; matriz_a = '0; matriz_b = '0;
    #12;
    check_idle_zero("rst_outs");
    check("rst_res", matriz_resultante, 225'(0));
    tick(1);
    reset = 1'b0;
    tick(1);
    check_idle_zero("idle_outs");

    // ---------------- Load ----------------
    for (int k = 0; k < 25; k++) begin
      matriz_a[9*k +: 9] = 9'(k);
      matriz_b[9*k +: 9] = 9'(100 + k);
    end
    g0 = grava_cnt;
    start = 1'b1; tick(1); start = 1'b0;             // after edge 0
    check("ld_busy", 225'(ocupado), 225'(1));
    check("ld_grava0", 225'(grava), 225'(1));
    check("ld_addr0", 225'(endereco), 225'(0));
    check("ld_data0", 225'(dado_saida), 225'(0));
    matriz_a = '1;                                    // must be ignored
    matriz_b = '0;
    tick(10);                                         // after edge 10
    start = 1'b1; resultado_pronto = 1'b1;
    tick(1);                                          // after edge 11
    start = 1'b0; resultado_pronto = 1'b0;
    check("ign_addr11", 225'(endereco), 225'(11));
    tick(38);                                         // after edge 49
    check("ld_addr49", 225'(endereco), 225'(49));
    check("ld_data49", 225'(dado_saida), 225'(124));
    check("ld_carr49", 225'(carregado), 225'(0));
    tick(1);                                          // after edge 50
    check("ld_carr50", 225'(carregado), 225'(1));
    check("ld_grava50", 225'(grava), 225'(0));
    check("ld_wcount", 225'(grava_cnt - g0), 225'(50));
    for (int k = 0; k < 50; k++)
      check("ld_ram", 225'(mem[k]), 225'((k < 25) ? k : (75 + k)));
    tick(5);
    check("ign_wait", 225'(carregado), 225'(1));

    // ---------------- Readback ----------------
    for (int j = 0; j < 25; j++) begin
      tb_we = 1'b1; tb_addr = 8'(50 + j); tb_data = 9'(511 - j);
      tick(1);
    end
    tb_we = 1'b0;
    check("rb_still_wait", 225'(carregado), 225'(1));
    for (int j = 0; j < 25; j++) exp_res[9*j +: 9] = 9'(511 - j);
    resultado_pronto = 1'b1; tick(1); resultado_pronto = 1'b0;  // after edge t
    check("rb_addr50", 225'(endereco), 225'(50));
    check("rb_carr_lo", 225'(carregado), 225'(0));
    tick(24);                                         // after t+24
    check("rb_addr74", 225'(endereco), 225'(74));
    tick(1);                                          // after t+25 (drain)
    check("rb_drain", 225'(endereco), 225'(74));
    check("rb_conc_early", 225'(concluido), 225'(0));
    tick(1);                                          // after t+26
    check("rb_conc", 225'(concluido), 225'(1));
    check("rb_res", matriz_resultante, exp_res);
    check("rb_e0", 225'(matriz_resultante[8:0]), 225'(511));
    check("rb_e24", 225'(matriz_resultante[224:216]), 225'(487));
    tick(1);                                          // after t+27
    check("rb_conc_pulse", 225'(concluido), 225'(0));
    check("rb_idle", 225'(ocupado), 225'(0));
    check("rb_hold", matriz_resultante, exp_res);

    // ---------------- Reset mid-operation ----------------
    for (int k = 0; k < 25; k++) begin
      matriz_a[9*k +: 9] = 9'(300 + k);
      matriz_b[9*k +: 9] = 9'(400 + k);
    end
    start = 1'b1; tick(1); start = 1'b0;             // after edge 0
    tick(30);                                         // after edge 30
    check("mr_addr30", 225'(endereco), 225'(30));
    check("mr_grava30", 225'(grava), 225'(1));
    #2 reset = 1'b1;
    #1;
    check_idle_zero("mr_outs");
    check("mr_res", matriz_resultante, 225'(0));
    @(posedge clk); #1 reset = 1'b0;
    check("mr_ram0", 225'(mem[0]), 225'(300));
    check("mr_ram24", 225'(mem[24]), 225'(324));
    check("mr_ram29", 225'(mem[29]), 225'(404));
    check("mr_ram30", 225'(mem[30]), 225'(105));
    check("mr_ram49", 225'(mem[49]), 225'(124));

    // ---------------- Back-to-back, resultado_pronto tied high ----------------
    resultado_pronto = 1'b1;
    for (int k = 0; k < 25; k++) begin
      matriz_a[9*k +: 9] = 9'(2*k + 1);
      matriz_b[9*k +: 9] = 9'(500 - k);
    end
    start = 1'b1; tick(1); start = 1'b0;             // after edge 0
    tick(49);                                         // after edge 49
    check("bb_grava49", 225'(grava), 225'(1));
    tick(1);                                          // after edge 50
    check("bb_carr50", 225'(carregado), 225'(1));
    tick(1);                                          // after edge 51 (t=51)
    check("bb_addr_le", 225'(endereco), 225'(50));
    tick(25);                                         // after edge 76
    check("bb_conc76", 225'(concluido), 225'(0));
    tick(1);                                          // after edge 77
    check("bb_conc77", 225'(concluido), 225'(1));
    check("bb_res1", matriz_resultante, exp_res);
    check("bb_busy77", 225'(ocupado), 225'(1));
    tick(1);                                          // after edge 78
    check("bb_conc78", 225'(concluido), 225'(0));
    check("bb_idle78", 225'(ocupado), 225'(0));
    for (int k = 0; k < 50; k++)
      check("bb_ram", 225'(mem[k]), 225'((k < 25) ? (2*k + 1) : (525 - k)));

    old_res = exp_res;
    for (int k = 0; k < 25; k++) begin
      matriz_a[9*k +: 9] = 9'(450 + k);
      matriz_b[9*k +: 9] = 9'(k);
    end
    start = 1'b1; tick(1); start = 1'b0;             // edge 79 = edge 0'
    check("bb2_busy", 225'(ocupado), 225'(1));
    check("bb2_data0", 225'(dado_saida), 225'(450));
    for (int j = 0; j < 25; j++) begin
      tb_we = 1'b1; tb_addr = 8'(50 + j); tb_data = 9'(3*j + 7);
      exp_res[9*j +: 9] = 9'(3*j + 7);
      tick(1);
    end
    tb_we = 1'b0;                                     // after edge 25'
    tick(51);                                         // after edge 76'
    check("bb2_res_old", matriz_resultante, old_res);
    check("bb2_conc76", 225'(concluido), 225'(0));
    tick(1);                                          // after edge 77'
    check("bb2_conc77", 225'(concluido), 225'(1));
    check("bb2_res_new", matriz_resultante, exp_res);
    tick(1);                                          // after edge 78'
    check("bb2_idle", 225'(ocupado), 225'(0));
    check("bb2_ram0", 225'(mem[0]), 225'(450));
    check("bb2_ram49", 225'(mem[49]), 225'(24));
    resultado_pronto = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
